vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA timing block.
- Generates pixel-rate enable, horizontal/vertical counters, sync pulses with configurable polarity, active-video flag, line/frame strobes and a frame counter.
- All timing derives from a single system clock via a programmable clock-enable divider; no derived clocks.
- Feeds the pattern/pixel pipeline and the VGA output pins on Basys 3.

---
 rtl/vga_timing_pkg.sv | 54 +++++
 rtl/vga_timing_gen_clk_en_div.sv | 29 ++
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 tb/tb_vga_timing_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants for the VGA timing generator: 640x480@60 geometry,
//   the 100 MHz -> 25 MHz pixel divider and the colour-bar palette.
//   Also provides timing_total() for line/frame totals and bar_rgb() for
//   the palette lookup used by the optional test pattern
//   (VGA_TEST_PATTERN_EN).
package vga_timing_pkg;

   localparam int unsigned CLK_DIV_100M  = 4;

   localparam int unsigned H_DISPLAY_640 = 640;
   localparam int unsigned H_FP_640      = 16;
   localparam int unsigned H_PULSE_640   = 96;
   localparam int unsigned H_BP_640      = 48;

   localparam int unsigned V_DISPLAY_480 = 480;
   localparam int unsigned V_FP_480      = 10;
   localparam int unsigned V_PULSE_480   = 2;
   localparam int unsigned V_BP_480      = 33;

   function automatic int unsigned timing_total(input int unsigned display,
                                                input int unsigned front_porch,
                                                input int unsigned pulse,
                                                input int unsigned back_porch);
      return display + front_porch + pulse + back_porch;
   endfunction

   localparam int unsigned H_TOTAL_640 = timing_total(H_DISPLAY_640, H_FP_640, H_PULSE_640, H_BP_640);
   localparam int unsigned V_TOTAL_480 = timing_total(V_DISPLAY_480, V_FP_480, V_PULSE_480, V_BP_480);

   // 4:4:4 colours, left-to-right bar order
   localparam logic [11:0] RGB_WHITE   = 12'hFFF;
   localparam logic [11:0] RGB_YELLOW  = 12'hFF0;
   localparam logic [11:0] RGB_CYAN    = 12'h0FF;
   localparam logic [11:0] RGB_GREEN   = 12'h0F0;
   localparam logic [11:0] RGB_MAGENTA = 12'hF0F;
   localparam logic [11:0] RGB_RED     = 12'hF00;
   localparam logic [11:0] RGB_BLUE    = 12'h00F;
   localparam logic [11:0] RGB_BLACK   = 12'h000;

   function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
      case (idx)
         3'd0:    return RGB_WHITE;
         3'd1:    return RGB_YELLOW;
         3'd2:    return RGB_CYAN;
         3'd3:    return RGB_GREEN;
         3'd4:    return RGB_MAGENTA;
         3'd5:    return RGB_RED;
         3'd6:    return RGB_BLUE;
         default: return RGB_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/vga_timing_gen_clk_en_div.sv
// clk_en_div
//   Clock-enable divider: tick is high for one system clock out of every
//   CLK_DIV clocks in which en is high. With CLK_DIV=1, tick follows en.
//   Ports: clk, rst (async, active-high), en (run enable), tick (enable out).
module clk_en_div #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      end
   end

   assign tick = en && (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA timing generator running from one system clock through
//   a clock-enable divider.
//   Ports:
//     clk, rst (async, active-high), en (run enable; low freezes state)
//     pix_en          pixel-rate enable (combinational)
//     h_count/v_count pixel / line position
//     h_sync/v_sync   sync pulses, active level HS_POL / VS_POL
//     display_active  inside the visible area
//     line_start      one-clock pulse when h_count wraps to 0
//     frame_start     one-clock pulse when both counters wrap to 0
//     frame_count     frames started since reset (16-bit, wrapping)
//     rgb             colour-bar test pattern, only with VGA_TEST_PATTERN_EN
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV       = CLK_DIV_100M,
   parameter int unsigned H_DISPLAY     = H_DISPLAY_640,
   parameter int unsigned H_FRONT_PORCH = H_FP_640,
   parameter int unsigned H_PULSE       = H_PULSE_640,
   parameter int unsigned H_BACK_PORCH  = H_BP_640,
   parameter int unsigned V_DISPLAY     = V_DISPLAY_480,
   parameter int unsigned V_FRONT_PORCH = V_FP_480,
   parameter int unsigned V_PULSE       = V_PULSE_480,
   parameter int unsigned V_BACK_PORCH  = V_BP_480,
   parameter logic        HS_POL        = 1'b0,
   parameter logic        VS_POL        = 1'b0,
   parameter int unsigned CNT_W         = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             pix_en,
   output logic [CNT_W-1:0] h_count,
   output logic [CNT_W-1:0] v_count,
   output logic             h_sync,
   output logic             v_sync,
   output logic             display_active,
   output logic             line_start,
   output logic             frame_start,
`ifdef VGA_TEST_PATTERN_EN
   output logic [11:0]      rgb,
`endif
   output logic [15:0]      frame_count
);

   localparam int unsigned H_TOTAL = timing_total(H_DISPLAY, H_FRONT_PORCH, H_PULSE, H_BACK_PORCH);
   localparam int unsigned V_TOTAL = timing_total(V_DISPLAY, V_FRONT_PORCH, V_PULSE, V_BACK_PORCH);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   // Sync windows kept 32-bit so an end bound equal to the total cannot overflow CNT_W
   localparam int unsigned HS_START = H_DISPLAY + H_FRONT_PORCH;
   localparam int unsigned HS_END   = HS_START + H_PULSE;
   localparam int unsigned VS_START = V_DISPLAY + V_FRONT_PORCH;
   localparam int unsigned VS_END   = VS_START + V_PULSE;

   logic             h_wrap, v_wrap;
   logic [CNT_W-1:0] h_next, v_next;
   logic             hs_next, vs_next, act_next;

   clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (pix_en)
   );

   // Decode from the next counter values so registered outputs line up with the counters
   always_comb begin
      h_wrap   = (h_count == H_LAST);
      v_wrap   = (v_count == V_LAST);
      h_next   = h_wrap ? '0 : h_count + 1'b1;
      v_next   = v_count;
      if (h_wrap) begin
         v_next = v_wrap ? '0 : v_count + 1'b1;
      end
      hs_next  = ((32'(h_next) >= HS_START) && (32'(h_next) < HS_END)) ? HS_POL : ~HS_POL;
      vs_next  = ((32'(v_next) >= VS_START) && (32'(v_next) < VS_END)) ? VS_POL : ~VS_POL;
      act_next = (32'(h_next) < H_DISPLAY) && (32'(v_next) < V_DISPLAY);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_count        <= H_LAST;
         v_count        <= V_LAST;
         h_sync         <= ~HS_POL;
         v_sync         <= ~VS_POL;
         display_active <= 1'b0;
         line_start     <= 1'b0;
         frame_start    <= 1'b0;
         frame_count    <= '0;
      end else if (pix_en) begin
         h_count        <= h_next;
         v_count        <= v_next;
         h_sync         <= hs_next;
         v_sync         <= vs_next;
         display_active <= act_next;
         line_start     <= h_wrap;
         frame_start    <= h_wrap && v_wrap;
         if (h_wrap && v_wrap) begin
            frame_count <= frame_count + 1'b1;
         end
      end else begin
         line_start     <= 1'b0;
         frame_start    <= 1'b0;
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   // Narrow displays still get width-1 bars; the last bar absorbs the remainder
   localparam int unsigned BAR_W = (H_DISPLAY / 8 > 0) ? H_DISPLAY / 8 : 1;

   int unsigned bar_q;
   logic [2:0]  bar_idx;

   always_comb begin
      bar_q   = 32'(h_next) / BAR_W;
      bar_idx = (bar_q > 7) ? 3'd7 : 3'(bar_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb <= '0;
      end else if (pix_en) begin
         rgb <= act_next ? bar_rgb(bar_idx) : '0;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

   localparam int HD = 3, HF = 1, HP = 2, HB = 1;
   localparam int VD = 4, VF = 1, VP = 2, VB = 1;
   localparam int HT = HD + HF + HP + HB;
   localparam int VT = VD + VF + VP + VB;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;

   always #5 clk = ~clk;

   // DUT A: CLK_DIV=2, active-low syncs.  DUT B: CLK_DIV=1, active-high syncs.
   logic          a_pe, a_hs, a_vs, a_da, a_ls, a_fs;
   logic [CW-1:0] a_h, a_v;
   logic [15:0]   a_fc;
   logic          b_pe, b_hs, b_vs, b_da, b_ls, b_fs;
   logic [CW-1:0] b_h, b_v;
   logic [15:0]   b_fc;
`ifdef VGA_TEST_PATTERN_EN
   logic [11:0]   a_rgb, b_rgb;
`endif

   vga_timing_gen #(
      .CLK_DIV(2), .H_DISPLAY(HD), .H_FRONT_PORCH(HF), .H_PULSE(HP), .H_BACK_PORCH(HB),
      .V_DISPLAY(VD), .V_FRONT_PORCH(VF), .V_PULSE(VP), .V_BACK_PORCH(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW)
   ) dut_a (
      .clk(clk), .rst(rst), .en(en), .pix_en(a_pe), .h_count(a_h), .v_count(a_v),
      .h_sync(a_hs), .v_sync(a_vs), .display_active(a_da), .line_start(a_ls),
      .frame_start(a_fs),
`ifdef VGA_TEST_PATTERN_EN
      .rgb(a_rgb),
`endif
      .frame_count(a_fc)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT_PORCH(HF), .H_PULSE(HP), .H_BACK_PORCH(HB),
      .V_DISPLAY(VD), .V_FRONT_PORCH(VF), .V_PULSE(VP), .V_BACK_PORCH(VB),
      .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW)
   ) dut_b (
      .clk(clk), .rst(rst), .en(en), .pix_en(b_pe), .h_count(b_h), .v_count(b_v),
      .h_sync(b_hs), .v_sync(b_vs), .display_active(b_da), .line_start(b_ls),
      .frame_start(b_fs),
`ifdef VGA_TEST_PATTERN_EN
      .rgb(b_rgb),
`endif
      .frame_count(b_fc)
   );

   typedef struct {
      int div, h, v, fc, hs, vs, da, ls, fs, pe, rgb;
   } exp_t;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int bar_colour(input int h);
      int idx;
      idx = (h > 7) ? 7 : h;  // bar width is 1 pixel for a 3-pixel display
      case (idx)
         0: return 'hFFF;
         1: return 'hFF0;
         2: return 'h0FF;
         3: return 'h0F0;
         4: return 'hF0F;
         5: return 'hF00;
         6: return 'h00F;
         default: return 'h000;
      endcase
   endfunction

   function automatic exp_t reset_state(input int hpol, input int vpol);
      exp_t m;
      m.div = 0; m.h = HT - 1; m.v = VT - 1; m.fc = 0;
      m.hs = 1 - hpol; m.vs = 1 - vpol; m.da = 0; m.ls = 0; m.fs = 0;
      m.pe = 0; m.rgb = 0;
      return m;
   endfunction

   // Reference behaviour for one rising edge with the given inputs
   function automatic exp_t advance(input exp_t m, input bit r, input bit e,
                                    input int cd, input int hpol, input int vpol);
      exp_t n;
      n = m;
      if (r) begin
         n = reset_state(hpol, vpol);
      end else if (e) begin
         if (m.div == cd - 1) begin
            n.h  = (m.h + 1) % HT;
            n.v  = (n.h == 0) ? (m.v + 1) % VT : m.v;
            n.ls = (n.h == 0);
            n.fs = (n.h == 0 && n.v == 0);
            if (n.fs) n.fc = (m.fc + 1) % 65536;
            n.hs = (n.h >= HD + HF && n.h < HD + HF + HP) ? hpol : 1 - hpol;
            n.vs = (n.v >= VD + VF && n.v < VD + VF + VP) ? vpol : 1 - vpol;
            n.da = (n.h < HD && n.v < VD) ? 1 : 0;
            n.rgb = n.da ? bar_colour(n.h) : 0;
         end else begin
            n.ls = 0; n.fs = 0;
         end
         n.div = (m.div + 1) % cd;
      end else begin
         n.ls = 0; n.fs = 0;
      end
      n.pe = (e && n.div == cd - 1) ? 1 : 0;
      return n;
   endfunction

   exp_t ma, mb, ea, eb;
   exp_t qa[$], qb[$];

   int cyc = 0;
   bit track = 0;
   int a_last_fs, a_last_ls, b_last_fs, a_act, b_act;

   task automatic compare(input string p, input exp_t e, input logic pe, input logic [CW-1:0] h,
                          input logic [CW-1:0] v, input logic hs, input logic vs, input logic da,
                          input logic ls, input logic fs, input logic [15:0] fc);
      check({p, "_pix_en"}, 32'(pe), e.pe);
      check({p, "_h_count"}, 32'(h), e.h);
      check({p, "_v_count"}, 32'(v), e.v);
      check({p, "_h_sync"}, 32'(hs), e.hs);
      check({p, "_v_sync"}, 32'(vs), e.vs);
      check({p, "_display_active"}, 32'(da), e.da);
      check({p, "_line_start"}, 32'(ls), e.ls);
      check({p, "_frame_start"}, 32'(fs), e.fs);
      check({p, "_frame_count"}, 32'(fc), e.fc);
   endtask

   task automatic clear_tracking();
      a_last_fs = -1; a_last_ls = -1; b_last_fs = -1; a_act = 0; b_act = 0;
   endtask

   // One clock: predict on the edge, compare half a period later
   task automatic tick_cycle();
      @(posedge clk);
      ma = advance(ma, rst, en, 2, 0, 0);
      mb = advance(mb, rst, en, 1, 1, 1);
      qa.push_back(ma);
      qb.push_back(mb);
      cyc++;
      @(negedge clk);
      ea = qa.pop_front();
      eb = qb.pop_front();
      compare("A", ea, a_pe, a_h, a_v, a_hs, a_vs, a_da, a_ls, a_fs, a_fc);
      compare("B", eb, b_pe, b_h, b_v, b_hs, b_vs, b_da, b_ls, b_fs, b_fc);
`ifdef VGA_TEST_PATTERN_EN
      check("A_rgb", 32'(a_rgb), ea.rgb);
      check("B_rgb", 32'(b_rgb), eb.rgb);
`endif
      if (track) begin
         if (a_ls) begin
            if (a_last_ls >= 0) check("A_line_period", cyc - a_last_ls, 14);
            a_last_ls = cyc;
         end
         if (a_fs) begin
            check("A_fs_has_ls", 32'(a_ls), 1);
            if (a_last_fs >= 0) begin
               check("A_frame_period", cyc - a_last_fs, 112);
               check("A_active_clks", a_act, 24);
            end
            a_last_fs = cyc; a_act = 0;
         end
         if (b_fs) begin
            if (b_last_fs >= 0) begin
               check("B_frame_period", cyc - b_last_fs, 56);
               check("B_active_clks", b_act, 12);
            end
            b_last_fs = cyc; b_act = 0;
         end
         if (a_da) a_act++;
         if (b_da) b_act++;
      end
   endtask

   initial begin
      int n;
      ma = reset_state(0, 0);
      mb = reset_state(1, 1);
      clear_tracking();
      rst = 1'b1;
      en  = 1'b1;
      repeat (3) tick_cycle();

      // first advance lands on the second enabled edge after release
      rst = 1'b0;
      n = 0;
      do begin
         tick_cycle();
         n++;
      end while (!a_fs && n < 10);
      check("A_first_adv_edge", n, 2);
      check("A_first_h", 32'(a_h), 0);
      check("A_first_v", 32'(a_v), 0);
      check("A_first_fc", 32'(a_fc), 1);

      track = 1'b1;
      repeat (3 * 112 + 5) tick_cycle();
      track = 1'b0;

      // freeze mid-line at h_count=2
      n = 0;
      while (!(ma.h == 2 && ma.div == 0) && n < 200) begin
         tick_cycle();
         n++;
      end
      check("A_reach_h2", (ma.h == 2 && ma.div == 0) ? 1 : 0, 1);
      en = 1'b0;
      repeat (5) begin
         tick_cycle();
         check("A_hold_h", 32'(a_h), 2);
         check("A_hold_ls", 32'(a_ls), 0);
      end
      en = 1'b1;
      repeat (2) tick_cycle();
      check("A_resume_h", 32'(a_h), 3);

      // asynchronous reset mid-frame at (h=1, v=3)
      n = 0;
      while (!(ma.v == 3 && ma.h == 1) && n < 300) begin
         tick_cycle();
         n++;
      end
      check("A_reach_v3h1", (ma.v == 3 && ma.h == 1) ? 1 : 0, 1);
      #2 rst = 1'b1;
      #1;
      check("A_arst_h", 32'(a_h), HT - 1);
      check("A_arst_v", 32'(a_v), VT - 1);
      check("A_arst_hs", 32'(a_hs), 1);
      check("A_arst_vs", 32'(a_vs), 1);
      check("A_arst_fc", 32'(a_fc), 0);
      check("B_arst_h", 32'(b_h), HT - 1);
      check("B_arst_hs", 32'(b_hs), 0);
      check("B_arst_vs", 32'(b_vs), 0);
      check("B_arst_fc", 32'(b_fc), 0);
      ma = reset_state(0, 0);
      mb = reset_state(1, 1);
      repeat (2) tick_cycle();
      rst = 1'b0;
      clear_tracking();
      track = 1'b1;
      repeat (2 * 112 + 3) tick_cycle();
      track = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
